// File: rtl/adder_issue_ctrl_if.sv
// rtl/adder_issue_ctrl_if.sv - operand and result streams of the adder issue stage
//
// Purpose:
//   Bundles the two valid/ready streams of adder_issue_ctrl.
//   The operand stream carries word pairs from the tile router.
//   The result stream carries sum/carry words downstream.
//
// Signals:
//   in_valid   operand word valid (router -> ctrl)
//   in_ready   operand word accepted (ctrl -> router)
//   in_a       operand A word
//   in_b       operand B word
//   in_last    most significant word of the packet
//   out_valid  result word valid (ctrl -> downstream)
//   out_ready  downstream accepts result
//   out_sum    result word
//   out_carry  carry-out of this word
//   out_last   last word of the packet
//
// Modports:
//   slave   the issue controller's view
//   master  the surrounding environment's view (router + downstream)

interface adder_issue_ctrl_if #(
  parameter int width = 16
) ();

  logic             in_valid;
  logic             in_ready;
  logic [width-1:0] in_a;
  logic [width-1:0] in_b;
  logic             in_last;

  logic             out_valid;
  logic             out_ready;
  logic [width-1:0] out_sum;
  logic             out_carry;
  logic             out_last;

  modport slave (
    input  in_valid,
    output in_ready,
    input  in_a,
    input  in_b,
    input  in_last,
    output out_valid,
    input  out_ready,
    output out_sum,
    output out_carry,
    output out_last
  );

  modport master (
    output in_valid,
    input  in_ready,
    output in_a,
    output in_b,
    output in_last,
    input  out_valid,
    output out_ready,
    input  out_sum,
    input  out_carry,
    input  out_last
  );

endinterface

// File: rtl/adder_issue_ctrl.sv
// rtl/adder_issue_ctrl.sv - operand issue and result collection around the tile adder
//
// Purpose:
//   Accepts operand words over valid/ready and registers them onto the adder inputs.
//   Waits for the adder's registered result and returns it over valid/ready.
//   Chains the carry across the words of a packet, so a width-bit adder performs
//   N*width-bit additions. Words are ordered least significant first, and in_last
//   marks the most significant word.
//
// Ports:
//   clk              rising-edge clock
//   reset            asynchronous active-high reset
//   enable           tile config enable; low = FU powered off
//   bus              operand/result streams (adder_issue_ctrl_if.slave)
//   fu_a, fu_b       registered operands to the adder
//   fu_carry_in      chained carry to the adder
//   fu_carry_listen  1 = adder adds fu_carry_in
//   fu_on_off        adder enable, combinational copy of enable
//   fu_c             adder sum
//   fu_carry_out     adder carry-out
//   fu_ack           adder result valid
//   busy             controller is not idle
//   err              sticky ack-timeout fault

module adder_issue_ctrl #(
  parameter int width       = 16,
  parameter int ACK_TIMEOUT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  adder_issue_ctrl_if.slave bus,
  output logic [width-1:0]  fu_a,
  output logic [width-1:0]  fu_b,
  output logic              fu_carry_in,
  output logic              fu_carry_listen,
  output logic              fu_on_off,
  input  logic [width-1:0]  fu_c,
  input  logic              fu_carry_out,
  input  logic              fu_ack,
  output logic              busy,
  output logic              err
);

  // The ack counter only has to count up to ACK_TIMEOUT-1.
  localparam int cnt_w = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [cnt_w-1:0] cnt_max = cnt_w'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    CAPT
  } state_t;

  state_t           state;
  state_t           state_next;

  logic [cnt_w-1:0] ack_cnt;
  logic             last_reg;
  logic             carry_reg;
  logic             chain_active;

  // Single-cycle strobes from the FSM to the datapath registers.
  logic             accept;
  logic             capture;
  logic             timeout;
  logic             abort;
  logic             cnt_clear;
  logic             cnt_inc;

  assign fu_on_off = enable;
  assign busy      = (state != IDLE);

  // Depends only on registered state and the downstream ready, never on in_valid.
  // Accepting while a result is pending is allowed only if that result leaves on
  // the same edge, so the output register is always free by the time of capture.
  assign bus.in_ready = enable && (state == IDLE) && (!bus.out_valid || bus.out_ready);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    capture    = 1'b0;
    timeout    = 1'b0;
    abort      = 1'b0;
    cnt_clear  = 1'b0;
    cnt_inc    = 1'b0;

    case (state)
      IDLE: begin
        if (bus.in_valid && bus.in_ready) begin
          accept     = 1'b1;
          state_next = EXEC;
        end
      end

      // The adder registers the sum at the end of this single cycle.
      EXEC: begin
        if (!enable) begin
          abort      = 1'b1;
          state_next = IDLE;
        end else begin
          cnt_clear  = 1'b1;
          state_next = CAPT;
        end
      end

      // Losing enable wins over a simultaneous ack: the FU is off, so its
      // result is not trusted.
      CAPT: begin
        if (!enable) begin
          abort      = 1'b1;
          state_next = IDLE;
        end else if (fu_ack) begin
          capture    = 1'b1;
          state_next = IDLE;
        end else if (ack_cnt == cnt_max) begin
          timeout    = 1'b1;
          state_next = IDLE;
        end else begin
          cnt_inc    = 1'b1;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Operand issue registers: hold their value except on accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fu_a            <= '0;
      fu_b            <= '0;
      fu_carry_in     <= 1'b0;
      fu_carry_listen <= 1'b0;
      last_reg        <= 1'b0;
    end else if (accept) begin
      fu_a            <= bus.in_a;
      fu_b            <= bus.in_b;
      last_reg        <= bus.in_last;
      // The first word of a packet must never see a stale carry.
      fu_carry_listen <= chain_active;
      fu_carry_in     <= carry_reg && chain_active;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ack_cnt <= '0;
    end else if (cnt_clear) begin
      ack_cnt <= '0;
    end else if (cnt_inc) begin
      ack_cnt <= ack_cnt + 1'b1;
    end
  end

  // Result register: loaded on capture, held until the downstream handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.out_valid <= 1'b0;
      bus.out_sum   <= '0;
      bus.out_carry <= 1'b0;
      bus.out_last  <= 1'b0;
    end else if (capture) begin
      bus.out_valid <= 1'b1;
      bus.out_sum   <= fu_c;
      bus.out_carry <= fu_carry_out;
      bus.out_last  <= last_reg;
    end else if (bus.out_valid && bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

  // Carry chain: a completed non-last word arms the chain for the next word.
  // Any dropped or aborted word, or the FU being off while idle, breaks it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      carry_reg    <= 1'b0;
      chain_active <= 1'b0;
    end else if (capture) begin
      carry_reg    <= fu_carry_out;
      chain_active <= !last_reg;
    end else if (timeout || abort || ((state == IDLE) && !enable)) begin
      carry_reg    <= 1'b0;
      chain_active <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err <= 1'b0;
    end else if (timeout) begin
      err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_adder_issue_ctrl.sv
// tb/tb_adder_issue_ctrl.sv - self-checking bench for adder_issue_ctrl

module tb_adder_issue_ctrl;

  localparam int W   = 16;
  localparam int ATO = 4;

  logic         clk;
  logic         reset;
  logic         enable;
  logic [W-1:0] fu_a;
  logic [W-1:0] fu_b;
  logic         fu_carry_in;
  logic         fu_carry_listen;
  logic         fu_on_off;
  logic [W-1:0] fu_c;
  logic         fu_carry_out;
  logic         fu_ack;
  logic         busy;
  logic         err;
  logic         ack_on;

  int errors;
  int checks;

  adder_issue_ctrl_if #(.width(W)) bus ();

  adder_issue_ctrl #(.width(W), .ACK_TIMEOUT(ATO)) dut (
    .clk             (clk),
    .reset           (reset),
    .enable          (enable),
    .bus             (bus),
    .fu_a            (fu_a),
    .fu_b            (fu_b),
    .fu_carry_in     (fu_carry_in),
    .fu_carry_listen (fu_carry_listen),
    .fu_on_off       (fu_on_off),
    .fu_c            (fu_c),
    .fu_carry_out    (fu_carry_out),
    .fu_ack          (fu_ack),
    .busy            (busy),
    .err             (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Adder model: registered sum of the current operands; ack is bench-controlled.
  always @(posedge clk) begin
    if (fu_on_off) begin
      {fu_carry_out, fu_c} <= {1'b0, fu_a} + {1'b0, fu_b} + {{W{1'b0}}, (fu_carry_listen & fu_carry_in)};
    end
  end
  assign fu_ack = ack_on;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         last;
    logic [W-1:0] sum;
    logic         carry;
    logic         listen;
    logic         cin;
  } vec_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         last;
  } word_t;

  typedef struct {
    logic [W-1:0] sum;
    logic         carry;
    logic         last;
  } res_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Present a word and return one step after the edge that accepted it.
  task automatic send_word(input logic [W-1:0] a, input logic [W-1:0] b, input logic last);
    logic ok;
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_last  = last;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (bus.in_ready) begin
        ok = 1'b1;
        step;
        break;
      end
      step;
    end
    bus.in_valid = 1'b0;
    chk("send_accept", {31'd0, ok}, 32'd1);
  endtask

  // Wait for a result, sample it, and let the handshake edge pass (out_ready=1).
  task automatic recv(output logic [W-1:0] s, output logic c, output logic l);
    logic ok;
    ok = 1'b0;
    s  = '0;
    c  = 1'b0;
    l  = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.out_valid) begin
        ok = 1'b1;
        s  = bus.out_sum;
        c  = bus.out_carry;
        l  = bus.out_last;
        break;
      end
      step;
    end
    chk("recv_valid", {31'd0, ok}, 32'd1);
    if (ok) step;
  endtask

  vec_t         vec [10];
  word_t        in_q[$];
  res_t         exp_q[$];
  word_t        w;
  res_t         r;
  res_t         e;
  logic [W-1:0] rs;
  logic         rc;
  logic         rl;
  logic [79:0]  big_a;
  logic [79:0]  big_b;
  logic [79:0]  part;
  logic [79:0]  mask;
  int           len;
  logic         acc_prev;
  logic         done;

  initial begin
    errors = 0;
    checks = 0;

    //            a         b         last  sum       carry listen cin
    vec[0] = '{16'h1234, 16'h0001, 1'b1, 16'h1235, 1'b0, 1'b0, 1'b0};
    vec[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0};
    vec[2] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b1, 1'b1};
    vec[3] = '{16'h8000, 16'h8000, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0};
    vec[4] = '{16'h0001, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b0};
    vec[5] = '{16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFE, 1'b1, 1'b0, 1'b0};
    vec[6] = '{16'hFFFF, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};
    vec[7] = '{16'h1000, 16'h2000, 1'b1, 16'h3001, 1'b0, 1'b1, 1'b1};
    vec[8] = '{16'h7FFF, 16'h0000, 1'b0, 16'h7FFF, 1'b0, 1'b0, 1'b0};
    vec[9] = '{16'h0001, 16'h0001, 1'b1, 16'h0002, 1'b0, 1'b1, 1'b0};

    reset         = 1'b1;
    enable        = 1'b1;
    ack_on        = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;

    // Reset state
    repeat (3) step;
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_fu_a", {16'd0, fu_a}, 32'd0);
    chk("rst_listen", {31'd0, fu_carry_listen}, 32'd0);
    reset = 1'b0;
    step;

    // Single word with exact latency
    bus.in_valid = 1'b1;
    bus.in_a     = 16'h1234;
    bus.in_b     = 16'h0001;
    bus.in_last  = 1'b1;
    #1;
    chk("single_in_ready", {31'd0, bus.in_ready}, 32'd1);
    step;
    bus.in_valid = 1'b0;
    chk("single_busy", {31'd0, busy}, 32'd1);
    chk("single_fu_a", {16'd0, fu_a}, 32'h1234);
    chk("single_listen", {31'd0, fu_carry_listen}, 32'd0);
    chk("single_ov_k", {31'd0, bus.out_valid}, 32'd0);
    step;
    chk("single_ov_k1", {31'd0, bus.out_valid}, 32'd0);
    step;
    chk("single_ov_k2", {31'd0, bus.out_valid}, 32'd1);
    chk("single_sum", {16'd0, bus.out_sum}, 32'h1235);
    chk("single_carry", {31'd0, bus.out_carry}, 32'd0);
    chk("single_last", {31'd0, bus.out_last}, 32'd1);
    step;
    chk("single_consumed", {31'd0, bus.out_valid}, 32'd0);

    // Table-driven words, including chains and packet boundaries
    for (int i = 0; i < 10; i++) begin
      send_word(vec[i].a, vec[i].b, vec[i].last);
      chk($sformatf("vec%0d_listen", i), {31'd0, fu_carry_listen}, {31'd0, vec[i].listen});
      chk($sformatf("vec%0d_cin", i), {31'd0, fu_carry_in}, {31'd0, vec[i].cin});
      recv(rs, rc, rl);
      chk($sformatf("vec%0d_sum", i), {16'd0, rs}, {16'd0, vec[i].sum});
      chk($sformatf("vec%0d_carry", i), {31'd0, rc}, {31'd0, vec[i].carry});
      chk($sformatf("vec%0d_last", i), {31'd0, rl}, {31'd0, vec[i].last});
    end

    // Backpressure: result held 10 cycles, next word accepted on the release edge
    bus.out_ready = 1'b0;
    send_word(16'h0010, 16'h0020, 1'b1);
    for (int i = 0; i < 10 && !bus.out_valid; i++) step;
    bus.in_valid = 1'b1;
    bus.in_a     = 16'h0100;
    bus.in_b     = 16'h0200;
    bus.in_last  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("bp_hold_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("bp_hold_sum", {16'd0, bus.out_sum}, 32'h0030);
      chk("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
      step;
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp_release_ready", {31'd0, bus.in_ready}, 32'd1);
    step;
    bus.in_valid = 1'b0;
    chk("bp_drained", {31'd0, bus.out_valid}, 32'd0);
    chk("bp_busy", {31'd0, busy}, 32'd1);
    chk("bp_fu_a", {16'd0, fu_a}, 32'h0100);
    recv(rs, rc, rl);
    chk("bp_sum2", {16'd0, rs}, 32'h0300);

    // Enable drop during CAPT of a non-last word
    send_word(16'h0005, 16'h0006, 1'b0);
    recv(rs, rc, rl);
    chk("en_first_sum", {16'd0, rs}, 32'h000B);
    ack_on = 1'b0;
    send_word(16'h1111, 16'h2222, 1'b0);
    step;
    enable = 1'b0;
    #1;
    chk("en_fu_off", {31'd0, fu_on_off}, 32'd0);
    chk("en_in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("en_busy_capt", {31'd0, busy}, 32'd1);
    step;
    chk("en_idle", {31'd0, busy}, 32'd0);
    chk("en_no_out", {31'd0, bus.out_valid}, 32'd0);
    enable = 1'b1;
    ack_on = 1'b1;
    send_word(16'h0003, 16'h0004, 1'b1);
    chk("en_listen", {31'd0, fu_carry_listen}, 32'd0);
    chk("en_cin", {31'd0, fu_carry_in}, 32'd0);
    chk("en_err", {31'd0, err}, 32'd0);
    recv(rs, rc, rl);
    chk("en_sum", {16'd0, rs}, 32'h0007);

    // Ack timeout after an armed chain
    send_word(16'hFFFF, 16'h0001, 1'b0);
    recv(rs, rc, rl);
    chk("to_first_carry", {31'd0, rc}, 32'd1);
    ack_on = 1'b0;
    send_word(16'h0001, 16'h0001, 1'b0);
    step;
    repeat (ATO - 1) step;
    chk("to_err_before", {31'd0, err}, 32'd0);
    chk("to_busy_before", {31'd0, busy}, 32'd1);
    step;
    chk("to_err", {31'd0, err}, 32'd1);
    chk("to_busy", {31'd0, busy}, 32'd0);
    chk("to_out_valid", {31'd0, bus.out_valid}, 32'd0);
    ack_on = 1'b1;
    send_word(16'h0010, 16'h0020, 1'b1);
    chk("to_listen", {31'd0, fu_carry_listen}, 32'd0);
    recv(rs, rc, rl);
    chk("to_sum", {16'd0, rs}, 32'h0030);
    chk("to_err_sticky", {31'd0, err}, 32'd1);

    // Asynchronous reset between edges while in EXEC
    send_word(16'h4444, 16'h1111, 1'b1);
    chk("rs_busy", {31'd0, busy}, 32'd1);
    #3;
    reset = 1'b1;
    #1;
    chk("rs_fu_a", {16'd0, fu_a}, 32'd0);
    chk("rs_fu_b", {16'd0, fu_b}, 32'd0);
    chk("rs_listen", {31'd0, fu_carry_listen}, 32'd0);
    chk("rs_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rs_busy0", {31'd0, busy}, 32'd0);
    chk("rs_err", {31'd0, err}, 32'd0);
    step;
    reset = 1'b0;
    step;
    send_word(16'h0002, 16'h0003, 1'b1);
    recv(rs, rc, rl);
    chk("rs_sum", {16'd0, rs}, 32'h0005);

    // Random multi-word packets against a whole-number reference
    for (int p = 0; p < 80; p++) begin
      len   = $urandom_range(1, 4);
      big_a = '0;
      big_b = '0;
      for (int i = 0; i < len; i++) begin
        w.a = 16'($urandom);
        w.b = 16'($urandom);
        if ($urandom_range(0, 3) == 0) w.a = 16'hFFFF;
        w.last = (i == len - 1);
        big_a[16*i +: 16] = w.a;
        big_b[16*i +: 16] = w.b;
        in_q.push_back(w);
      end
      for (int i = 0; i < len; i++) begin
        mask    = (80'd1 << (16 * (i + 1))) - 80'd1;
        part    = (big_a & mask) + (big_b & mask);
        r.sum   = part[16*i +: 16];
        r.carry = part[16*(i+1)];
        r.last  = (i == len - 1);
        exp_q.push_back(r);
      end
    end

    acc_prev = 1'b0;
    done     = 1'b0;
    for (int cyc = 0; cyc < 20000 && !done; cyc++) begin
      step;
      if (acc_prev) begin
        void'(in_q.pop_front());
        bus.in_valid = 1'b0;
      end
      if (!bus.in_valid && in_q.size() > 0 && $urandom_range(0, 3) != 0) begin
        bus.in_valid = 1'b1;
        bus.in_a     = in_q[0].a;
        bus.in_b     = in_q[0].b;
        bus.in_last  = in_q[0].last;
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
      #1;
      acc_prev = bus.in_valid && bus.in_ready;
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("rand_extra_result", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("rand_result", {13'd0, bus.out_last, bus.out_carry, bus.out_sum},
              {13'd0, e.last, e.carry, e.sum});
        end
      end
      if (exp_q.size() == 0) done = 1'b1;
    end
    step;
    bus.in_valid = 1'b0;
    chk("rand_all_results", exp_q.size(), 32'd0);
    chk("rand_err_clear", {31'd0, err}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
